// File: rtl/arm_pkg.sv
// Shared types and widths for the ARM calculator datapath stages.
package arm_pkg;

    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef struct packed {
        logic                  wb_valid;
        logic [DATA_W-1:0]     read_data;
        logic [DATA_W-1:0]     alu_result;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] wa3;
        logic                  fault;
    } wb_bundle_t;

    // A store wins when both MemWrite and MemtoReg are set, so either flag means a bus op.
    function automatic logic is_mem_op(input logic mem_write, input logic mem_to_reg);
        return mem_write | mem_to_reg;
    endfunction

    function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// Memory/write-back pipeline register; wb_valid and fault self-clear so they pulse for one cycle.
module mem_wb_reg
    import arm_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_i,
    input  wb_bundle_t bundle_i,
    output wb_bundle_t bundle_o
);

    wb_bundle_t bundle_q;
    wb_bundle_t bundle_d;

    always_comb begin
        bundle_d = bundle_q;
        bundle_d.wb_valid = 1'b0;
        bundle_d.fault    = 1'b0;
        if (load_i) begin
            bundle_d = bundle_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bundle_q <= '0;
        end else begin
            bundle_q <= bundle_d;
        end
    end

    assign bundle_o = bundle_q;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: word loads/stores over a req/ack bus with timeout, feeding write-back.
module mem_access_stage
    import arm_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [DATA_W-1:0]     ALUResult_in,
    input  logic [DATA_W-1:0]     WriteData_in,
    input  logic                  MemWrite_in,
    input  logic                  MemtoReg_in,
    input  logic                  RegWrite_in,
    input  logic [REG_ADDR_W-1:0] WA3_in,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  wb_valid,
    output logic [DATA_W-1:0]     ReadData,
    output logic [DATA_W-1:0]     ALUResult,
    output logic                  MemtoReg,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WA3,
    output logic                  fault
);

    // Counter value during the last permitted request cycle.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  mtr_q, mtr_d;
    logic                  rw_q, rw_d;
    logic [REG_ADDR_W-1:0] wa3_q, wa3_d;

    logic                  wb_load;
    wb_bundle_t            wb_next;
    wb_bundle_t            wb_out;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        mtr_d   = mtr_q;
        rw_d    = rw_q;
        wa3_d   = wa3_q;
        wb_load = 1'b0;
        wb_next = '0;

        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (!is_mem_op(MemWrite_in, MemtoReg_in)) begin
                        wb_load            = 1'b1;
                        wb_next.wb_valid   = 1'b1;
                        wb_next.alu_result = ALUResult_in;
                        wb_next.mem_to_reg = MemtoReg_in;
                        wb_next.reg_write  = RegWrite_in;
                        wb_next.wa3        = WA3_in;
                    end else if (is_misaligned(ALUResult_in)) begin
                        wb_load            = 1'b1;
                        wb_next.wb_valid   = 1'b1;
                        wb_next.alu_result = ALUResult_in;
                        wb_next.mem_to_reg = MemtoReg_in;
                        wb_next.wa3        = WA3_in;
                        wb_next.fault      = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        addr_d  = {ALUResult_in[DATA_W-1:2], 2'b00};
                        wdata_d = WriteData_in;
                        we_d    = MemWrite_in;
                        mtr_d   = MemtoReg_in;
                        rw_d    = RegWrite_in;
                        wa3_d   = WA3_in;
                    end
                end
            end
            BUSY: begin
                // Ack is examined first so an ack on the final permitted cycle is not a fault.
                if (mem_ack) begin
                    state_d            = IDLE;
                    wb_load            = 1'b1;
                    wb_next.wb_valid   = 1'b1;
                    wb_next.read_data  = we_q ? '0 : mem_rdata;
                    wb_next.alu_result = addr_q;
                    wb_next.mem_to_reg = mtr_q;
                    wb_next.reg_write  = rw_q;
                    wb_next.wa3        = wa3_q;
                end else if (cnt_q >= TO_LAST) begin
                    state_d            = IDLE;
                    wb_load            = 1'b1;
                    wb_next.wb_valid   = 1'b1;
                    wb_next.alu_result = addr_q;
                    wb_next.mem_to_reg = mtr_q;
                    wb_next.wa3        = wa3_q;
                    wb_next.fault      = 1'b1;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            mtr_q   <= 1'b0;
            rw_q    <= 1'b0;
            wa3_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            mtr_q   <= mtr_d;
            rw_q    <= rw_d;
            wa3_q   <= wa3_d;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (wb_load),
        .bundle_i (wb_next),
        .bundle_o (wb_out)
    );

    assign ready_out = (state_q == IDLE);
    assign mem_req   = (state_q == BUSY);
    assign mem_we    = (state_q == BUSY) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign wb_valid  = wb_out.wb_valid;
    assign ReadData  = wb_out.read_data;
    assign ALUResult = wb_out.alu_result;
    assign MemtoReg  = wb_out.mem_to_reg;
    assign RegWrite  = wb_out.reg_write;
    assign WA3       = wb_out.wa3;
    assign fault     = wb_out.fault;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage built with TIMEOUT=4.
module tb_mem_access_stage;

    logic        clk;
    logic        reset_n;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] ALUResult_in;
    logic [31:0] WriteData_in;
    logic        MemWrite_in;
    logic        MemtoReg_in;
    logic        RegWrite_in;
    logic [3:0]  WA3_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic [31:0] ReadData;
    logic [31:0] ALUResult;
    logic        MemtoReg;
    logic        RegWrite;
    logic [3:0]  WA3;
    logic        fault;

    int errors = 0;
    int checks = 0;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .ALUResult_in (ALUResult_in),
        .WriteData_in (WriteData_in),
        .MemWrite_in  (MemWrite_in),
        .MemtoReg_in  (MemtoReg_in),
        .RegWrite_in  (RegWrite_in),
        .WA3_in       (WA3_in),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .wb_valid     (wb_valid),
        .ReadData     (ReadData),
        .ALUResult    (ALUResult),
        .MemtoReg     (MemtoReg),
        .RegWrite     (RegWrite),
        .WA3          (WA3),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                         input logic mw, input logic mtr, input logic rw, input logic [3:0] wa);
        valid_in     = v;
        ALUResult_in = alu;
        WriteData_in = wd;
        MemWrite_in  = mw;
        MemtoReg_in  = mtr;
        RegWrite_in  = rw;
        WA3_in       = wa;
    endtask

    initial begin
        reset_n   = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        drive(1'b1, 32'hFFFF_FFF0, 32'hAAAA_5555, 1'b0, 1'b1, 1'b1, 4'hF);

        // Reset held two cycles with valid_in asserted
        step();
        step();
        chk1 ("rst_mem_req",  mem_req,   1'b0);
        chk1 ("rst_wb_valid", wb_valid,  1'b0);
        chk1 ("rst_fault",    fault,     1'b0);
        chk32("rst_ReadData", ReadData,  32'h0);
        chk32("rst_ALURes",   ALUResult, 32'h0);
        chk32("rst_mem_addr", mem_addr,  32'h0);
        reset_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        step();
        chk1 ("rst_ready",    ready_out, 1'b1);
        chk1 ("rst_wb_valid2", wb_valid, 1'b0);
        chk1 ("rst_RegWrite", RegWrite,  1'b0);
        chk1 ("rst_MemtoReg", MemtoReg,  1'b0);
        chk32("rst_WA3",      {28'h0, WA3}, 32'h0);

        // ALU pass-through
        drive(1'b1, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b1, 4'd3);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        chk1 ("alu_wb_valid", wb_valid,  1'b1);
        chk32("alu_ALURes",   ALUResult, 32'h1234_5678);
        chk32("alu_WA3",      {28'h0, WA3}, 32'd3);
        chk32("alu_ReadData", ReadData,  32'h0);
        chk1 ("alu_RegWrite", RegWrite,  1'b1);
        chk1 ("alu_mem_req",  mem_req,   1'b0);
        chk1 ("alu_fault",    fault,     1'b0);
        step();
        chk1 ("alu_pulse",    wb_valid,  1'b0);

        // Back-to-back non-memory ops
        drive(1'b1, 32'h0000_00A1, 32'h0, 1'b0, 1'b0, 1'b1, 4'd1);
        step();
        chk32("b2b_first",    ALUResult, 32'h0000_00A1);
        chk1 ("b2b_ready",    ready_out, 1'b1);
        drive(1'b1, 32'h0000_00B2, 32'h0, 1'b0, 1'b0, 1'b0, 4'd2);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        chk1 ("b2b_valid2",   wb_valid,  1'b1);
        chk32("b2b_second",   ALUResult, 32'h0000_00B2);
        chk1 ("b2b_rw2",      RegWrite,  1'b0);

        // Load at 0x100, ack in the fourth request cycle (also the last before timeout)
        drive(1'b1, 32'h0000_0100, 32'h0, 1'b0, 1'b1, 1'b1, 4'd5);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            chk1 ("ld_mem_req",  mem_req,   1'b1);
            chk1 ("ld_mem_we",   mem_we,    1'b0);
            chk32("ld_mem_addr", mem_addr,  32'h0000_0100);
            chk1 ("ld_ready",    ready_out, 1'b0);
            chk1 ("ld_no_wb",    wb_valid,  1'b0);
            if (i == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
            step();
        end
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        chk1 ("ld_wb_valid", wb_valid,  1'b1);
        chk32("ld_ReadData", ReadData,  32'hDEAD_BEEF);
        chk1 ("ld_MemtoReg", MemtoReg,  1'b1);
        chk1 ("ld_RegWrite", RegWrite,  1'b1);
        chk32("ld_WA3",      {28'h0, WA3}, 32'd5);
        chk1 ("ld_fault",    fault,     1'b0);
        chk1 ("ld_req_drop", mem_req,   1'b0);
        chk1 ("ld_ready_back", ready_out, 1'b1);

        // Store at 0x104 with immediate ack
        drive(1'b1, 32'h0000_0104, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 4'd0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        chk1 ("st_mem_req",   mem_req,   1'b1);
        chk1 ("st_mem_we",    mem_we,    1'b1);
        chk32("st_mem_addr",  mem_addr,  32'h0000_0104);
        chk32("st_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_1111;
        step();
        mem_ack   = 1'b0;
        chk1 ("st_wb_valid",  wb_valid,  1'b1);
        chk32("st_ReadData",  ReadData,  32'h0);
        chk1 ("st_fault",     fault,     1'b0);

        // MemWrite and MemtoReg both set: store, MemtoReg passes through
        drive(1'b1, 32'h0000_0108, 32'h0BAD_CAFE, 1'b1, 1'b1, 1'b0, 4'd7);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        chk1 ("both_mem_we",  mem_we,    1'b1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h2222_2222;
        step();
        mem_ack   = 1'b0;
        chk32("both_ReadData", ReadData, 32'h0);
        chk1 ("both_MemtoReg", MemtoReg, 1'b1);

        // Misaligned load
        drive(1'b1, 32'h0000_0102, 32'h0, 1'b0, 1'b1, 1'b1, 4'd9);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        chk1 ("mis_mem_req",  mem_req,   1'b0);
        chk1 ("mis_wb_valid", wb_valid,  1'b1);
        chk1 ("mis_fault",    fault,     1'b1);
        chk1 ("mis_RegWrite", RegWrite,  1'b0);
        chk1 ("mis_ready",    ready_out, 1'b1);
        step();
        chk1 ("mis_fault_pulse", fault,  1'b0);

        // Timeout: no ack for four request cycles
        drive(1'b1, 32'h0000_0200, 32'h0, 1'b0, 1'b1, 1'b1, 4'd4);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            chk1 ("to_mem_req", mem_req, 1'b1);
            step();
        end
        chk1 ("to_req_drop",  mem_req,   1'b0);
        chk1 ("to_wb_valid",  wb_valid,  1'b1);
        chk1 ("to_fault",     fault,     1'b1);
        chk1 ("to_RegWrite",  RegWrite,  1'b0);
        chk1 ("to_ready",     ready_out, 1'b1);
        step();
        chk1 ("to_wb_pulse",  wb_valid,  1'b0);

        // Ack while idle is ignored
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk1 ("idle_ack_wb",  wb_valid,  1'b0);
        chk1 ("idle_ack_req", mem_req,   1'b0);

        // Reset in the middle of an access
        drive(1'b1, 32'h0000_0300, 32'h0, 1'b0, 1'b1, 1'b1, 4'd6);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        chk1 ("rb_mem_req",   mem_req,   1'b1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk1 ("rb_req_low",   mem_req,   1'b0);
        chk1 ("rb_ready",     ready_out, 1'b1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk1 ("rb_no_wb",     wb_valid,  1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
